// File: rtl/ir_command_receiver_pkg.sv
// Shared definitions for the IR toy-car link: FSM states, burst classes,
// default burst sizes and the burst-length classifier.
package ir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        BITS = 2'd2,
        DONE = 2'd3
    } ir_state_e;

    typedef enum logic [1:0] {
        START = 2'd0,
        ONE   = 2'd1,
        ZERO  = 2'd2,
        BAD   = 2'd3
    } burst_class_e;

    // Default link constants, common to transmitter and receiver
    localparam int DEF_ENV_TIMEOUT   = 1500;
    localparam int DEF_START_SIZE    = 88;
    localparam int DEF_SELECT_SIZE   = 22;
    localparam int DEF_ASSERT_SIZE   = 44;
    localparam int DEF_DEASSERT_SIZE = 22;
    localparam int DEF_TOL           = 4;
    localparam int DEF_GAP_MAX       = 100000;

    // True when n lies within size +/- tol; 9-bit signed so nothing wraps
    function automatic logic within_tol(input logic [7:0]        n,
                                        input logic signed [8:0] size,
                                        input logic signed [8:0] tol);
        logic signed [8:0] diff;
        diff = $signed({1'b0, n}) - size;
        return (diff <= tol) && (diff >= -tol);
    endfunction

    // First match wins: START, then ONE, then ZERO (also the select length)
    function automatic burst_class_e classify_burst(input logic [7:0]        n,
                                                    input logic signed [8:0] start_sz,
                                                    input logic signed [8:0] assert_sz,
                                                    input logic signed [8:0] deassert_sz,
                                                    input logic signed [8:0] tol);
        burst_class_e cls;
        if (within_tol(n, start_sz, tol)) begin
            cls = START;
        end else if (within_tol(n, assert_sz, tol)) begin
            cls = ONE;
        end else if (within_tol(n, deassert_sz, tol)) begin
            cls = ZERO;
        end else begin
            cls = BAD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ir_command_receiver_envelope.sv
// Synchronises the raw IR input, detects carrier rising edges, tracks the
// burst envelope with a timeout and counts carrier cycles per burst.
module ir_envelope_detector #(
    parameter int ENV_TIMEOUT = 1500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ir_in,
    output logic       env,
    output logic       env_fall,
    output logic [7:0] burst_len
);

    localparam int              TW       = $clog2(ENV_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(ENV_TIMEOUT - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q,  prev_d;
    logic          env_q,   env_d;
    logic          fall_q,  fall_d;
    logic [TW-1:0] tmo_q,   tmo_d;
    logic [7:0]    cnt_q,   cnt_d;
    logic [7:0]    len_q,   len_d;
    logic          rise_s;

    assign rise_s = sync2_q & ~prev_q;

    // Next-state: an edge always re-arms the envelope, even on a timeout cycle
    always_comb begin
        sync1_d = ir_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        env_d   = env_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fall_d  = 1'b0;
        if (rise_s) begin
            env_d = 1'b1;
            tmo_d = '0;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (env_q) begin
            if (tmo_q == TMO_LAST) begin
                // Burst over: hand the length to the classifier and restart counting
                env_d  = 1'b0;
                tmo_d  = '0;
                fall_d = 1'b1;
                len_d  = cnt_q;
                cnt_d  = 8'd0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            env_q   <= 1'b0;
            fall_q  <= 1'b0;
            tmo_q   <= '0;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            env_q   <= env_d;
            fall_q  <= fall_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign env       = env_q;
    assign env_fall  = fall_q;
    assign burst_len = len_q;

endmodule

// File: rtl/ir_command_receiver.sv
// IR toy-car command decoder: classifies carrier bursts and walks the
// start / select / four-bit frame, publishing the command on success.
module ir_command_receiver
    import ir_pkg::*;
#(
    parameter int ENV_TIMEOUT   = DEF_ENV_TIMEOUT,
    parameter int START_SIZE    = DEF_START_SIZE,
    parameter int SELECT_SIZE   = DEF_SELECT_SIZE,
    parameter int ASSERT_SIZE   = DEF_ASSERT_SIZE,
    parameter int DEASSERT_SIZE = DEF_DEASSERT_SIZE,
    parameter int TOL           = DEF_TOL,
    parameter int GAP_MAX       = DEF_GAP_MAX
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IR_IN,
    output logic [3:0] COMMAND,
    output logic       CMD_VALID,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int                GW          = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0]     GAP_MAX_C   = GW'(GAP_MAX);
    localparam logic signed [8:0] START_SZ_C  = 9'(START_SIZE);
    localparam logic signed [8:0] ASSERT_SZ_C = 9'(ASSERT_SIZE);
    localparam logic signed [8:0] DEASS_SZ_C  = 9'(DEASSERT_SIZE);
    localparam logic signed [8:0] TOL_C       = 9'(TOL);

    logic         env_s;
    logic         env_fall_s;
    logic [7:0]   burst_len_s;
    burst_class_e cls_s;

    ir_state_e    state_q,     state_d;
    logic [1:0]   idx_q,       idx_d;
    logic [3:0]   shreg_q,     shreg_d;
    logic [GW-1:0] gap_q,      gap_d;
    logic [3:0]   command_q,   command_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic         frame_err_q, frame_err_d;
    logic         busy_q,      busy_d;

    ir_envelope_detector #(
        .ENV_TIMEOUT (ENV_TIMEOUT)
    ) u_env (
        .clk       (CLK),
        .rst_n     (RST),
        .ir_in     (IR_IN),
        .env       (env_s),
        .env_fall  (env_fall_s),
        .burst_len (burst_len_s)
    );

    // SELECT has the ZERO length, so only three sizes need comparing
    assign cls_s = classify_burst(burst_len_s, START_SZ_C, ASSERT_SZ_C, DEASS_SZ_C, TOL_C);

    // Frame FSM next-state, gap watchdog and output pulses
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        command_d   = command_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;

        // Watchdog only counts envelope-low time inside a frame
        if ((state_q == SEL || state_q == BITS) && !env_s) begin
            if (gap_q == GAP_MAX_C) begin
                gap_d = gap_q;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end else begin
            gap_d = '0;
        end

        case (state_q)
            IDLE: begin
                // Stray bursts outside a frame are dropped without an error
                if (env_fall_s && cls_s == START) begin
                    state_d = SEL;
                end else begin
                    state_d = IDLE;
                end
            end
            SEL: begin
                if (gap_q == GAP_MAX_C) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (env_fall_s) begin
                    if (cls_s == ZERO) begin
                        state_d = BITS;
                        idx_d   = 2'd0;
                        shreg_d = 4'd0;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = SEL;
                end
            end
            BITS: begin
                if (gap_q == GAP_MAX_C) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (env_fall_s) begin
                    case (cls_s)
                        ONE, ZERO: begin
                            shreg_d[idx_q] = (cls_s == ONE);
                            idx_d          = idx_q + 2'd1;
                            if (idx_q == 2'd3) begin
                                state_d = DONE;
                            end else begin
                                state_d = BITS;
                            end
                        end
                        default: begin
                            state_d     = IDLE;
                            frame_err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = BITS;
                end
            end
            DONE: begin
                command_d   = shreg_q;
                cmd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            shreg_q     <= 4'd0;
            gap_q       <= '0;
            command_q   <= 4'd0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            gap_q       <= gap_d;
            command_q   <= command_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign COMMAND   = command_q;
    assign CMD_VALID = cmd_valid_q;
    assign FRAME_ERR = frame_err_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_ir_command_receiver.sv
// Self-checking bench for ir_command_receiver with a scaled-down carrier
// and timeouts so whole frames fit in a short run.
module tb_ir_command_receiver;

    localparam int ET   = 20;   // envelope timeout
    localparam int SS   = 88;
    localparam int SELS = 22;
    localparam int AS   = 44;
    localparam int DS   = 22;
    localparam int TOL  = 4;
    localparam int GM   = 400;  // gap limit
    localparam int CH   = 3;    // carrier half period in clocks

    localparam int C_START = 0, C_ONE = 1, C_ZERO = 2, C_BAD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ir = 1'b0;
    logic [3:0] command;
    logic       cmd_valid, frame_err, busy;

    always #10 clk = ~clk;

    ir_command_receiver #(
        .ENV_TIMEOUT(ET), .START_SIZE(SS), .SELECT_SIZE(SELS), .ASSERT_SIZE(AS),
        .DEASSERT_SIZE(DS), .TOL(TOL), .GAP_MAX(GM)
    ) dut (
        .CLK(clk), .RST(rst_n), .IR_IN(ir), .COMMAND(command),
        .CMD_VALID(cmd_valid), .FRAME_ERR(frame_err), .BUSY(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [3:0] cmd;
        int         t_min;
        int         t_max;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_ev;
    logic [3:0] model_cmd = 4'd0;
    bit         in_frame = 1'b0;
    bit         got_sel = 1'b0;
    bit         bits_q[$];
    int         last_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Spec-level burst classification by absolute distance
    function automatic int classify(input int n);
        int d_s, d_a, d_d;
        d_s = (n > SS) ? n - SS : SS - n;
        d_a = (n > AS) ? n - AS : AS - n;
        d_d = (n > DS) ? n - DS : DS - n;
        if (d_s <= TOL) return C_START;
        if (d_a <= TOL) return C_ONE;
        if (d_d <= TOL) return C_ZERO;
        return C_BAD;
    endfunction

    task automatic push_event(input bit is_err, input logic [3:0] cmd, input int lo, input int hi);
        ev_t e;
        e.is_err = is_err;
        e.cmd    = cmd;
        e.t_min  = lo;
        e.t_max  = hi;
        exp_q.push_back(e);
    endtask

    // Frame rules: start, select-length burst, then four data bits
    task automatic model_burst(input int n);
        int cls;
        cls = classify(n);
        if (!in_frame) begin
            if (cls == C_START) begin
                in_frame = 1'b1;
                got_sel  = 1'b0;
                bits_q.delete();
            end
        end else if (!got_sel) begin
            if (cls == C_ZERO) begin
                got_sel = 1'b1;
            end else begin
                push_event(1'b1, 4'd0, last_edge + ET, last_edge + ET + 5);
                in_frame = 1'b0;
            end
        end else if (cls == C_ONE || cls == C_ZERO) begin
            bits_q.push_back(cls == C_ONE);
            if (bits_q.size() == 4) begin
                push_event(1'b0, {bits_q[3], bits_q[2], bits_q[1], bits_q[0]},
                           last_edge + ET, last_edge + ET + 5);
                in_frame = 1'b0;
            end
        end else begin
            push_event(1'b1, 4'd0, last_edge + ET, last_edge + ET + 5);
            in_frame = 1'b0;
        end
    endtask

    // Quiet-point check: nothing pending and BUSY follows the frame model
    task automatic checkpoint();
        check("busy", {31'd0, busy}, {31'd0, in_frame});
        check("pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_burst(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ir = 1'b1;
            last_edge = cyc;
            repeat (CH) @(negedge clk);
            ir = 1'b0;
            repeat (CH - 1) @(negedge clk);
        end
        model_burst(n);
        if (gap >= ET + 12) begin
            repeat (ET + 10) @(negedge clk);
            #2;
            checkpoint();
            repeat (gap - ET - 10) @(negedge clk);
        end else begin
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [3:0] cmd, input bit jitter,
                              input int bad_slot, input int bad_len, input int gap);
        int lens[6];
        lens[0] = SS;
        lens[1] = SELS;
        for (int b = 0; b < 4; b++) lens[b + 2] = cmd[b] ? AS : DS;
        for (int k = 0; k < 6; k++) begin
            if (jitter) lens[k] = lens[k] + $urandom_range(0, 2 * TOL) - TOL;
            if (k == bad_slot) lens[k] = bad_len;
            send_burst(lens[k], (gap == 0) ? $urandom_range(40, 120) : gap);
        end
    endtask

    task automatic silence(input int len);
        if (in_frame) begin
            push_event(1'b1, 4'd0, last_edge + ET + GM - 5, last_edge + ET + GM + 10);
            in_frame = 1'b0;
        end
        repeat (len) @(negedge clk);
        #2;
        checkpoint();
    endtask

    task automatic expect_lit(input string name, input logic [3:0] v, input logic b);
        check({name, "_dut"}, {28'd0, command}, {28'd0, v});
        check({name, "_model"}, {28'd0, model_cmd}, {28'd0, v});
        check({name, "_busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    // Per-cycle compare of pulses and COMMAND against the model
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cmd_valid === 1'b1 || frame_err === 1'b1) begin
                check("pulse_exclusive", {31'd0, cmd_valid & frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, cmd_valid, frame_err}, 32'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, mon_ev.is_err});
                    check("pulse_time", cyc, (cyc < mon_ev.t_min) ? mon_ev.t_min :
                                             (cyc > mon_ev.t_max) ? mon_ev.t_max : cyc);
                    if (!mon_ev.is_err) model_cmd = mon_ev.cmd;
                end
            end
            check("command", {28'd0, command}, {28'd0, model_cmd});
        end
    end

    // Hard bound on run time
    initial begin
        #1_600_000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        #2;
        check("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        expect_lit("reset", 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 88/22/22/44/22/22 decodes to 2
        send_frame(4'h2, 1'b0, -1, 0, 60);
        expect_lit("frame_2", 4'h2, 1'b0);
        send_frame(4'hF, 1'b0, -1, 0, 60);
        expect_lit("frame_F", 4'hF, 1'b0);
        send_frame(4'h0, 1'b0, -1, 0, 60);
        expect_lit("frame_0", 4'h0, 1'b0);

        // Short start is ignored silently
        send_burst(70, 100);
        expect_lit("short_start", 4'h0, 1'b0);

        // Wrong-length burst while waiting for select
        send_burst(SS, 60);
        send_burst(60, 60);
        expect_lit("bad_select", 4'h0, 1'b0);

        // Gap watchdog after start + select
        send_burst(SS, 60);
        send_burst(SELS, 60);
        silence(GM + ET + 60);
        expect_lit("gap_timeout", 4'h0, 1'b0);

        // Reset two bits into a frame that follows a good A frame
        send_frame(4'hA, 1'b0, -1, 0, 60);
        expect_lit("frame_A", 4'hA, 1'b0);
        send_burst(SS, 60);
        send_burst(SELS, 60);
        send_burst(AS, 60);
        send_burst(DS, 5);
        @(negedge clk);
        rst_n = 1'b0;
        in_frame = 1'b0;
        exp_q.delete();
        model_cmd = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
            check("rst_frame_err", {31'd0, frame_err}, 32'd0);
            expect_lit("mid_reset", 4'h0, 1'b0);
        end
        rst_n = 1'b1;
        repeat (ET + 40) @(negedge clk);
        #2;
        checkpoint();
        send_frame(4'h5, 1'b0, -1, 0, 60);
        expect_lit("frame_5", 4'h5, 1'b0);

        // Randomised frames with jitter and occasional corrupted bursts
        for (int f = 0; f < 8; f++) begin
            int slot;
            slot = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
            if ($urandom_range(0, 3) == 0) send_burst($urandom_range(10, 120), 60);
            send_frame(4'($urandom_range(0, 15)), 1'b1, slot, $urandom_range(10, 120), 0);
        end

        repeat (ET + 30) @(negedge clk);
        #2;
        checkpoint();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
